// File: rtl/tdm_demux16_if.sv
// Serial TDM input side and demultiplexed frame/status side of tdm_demux16.
interface tdm_demux16_if;
    logic        din;
    logic        din_valid;
    logic        frame_sync;
    logic [15:0] dout;
    logic        dout_valid;
    logic [3:0]  slot;
    logic        locked;
    logic        frame_err;

    modport slave (
        input  din, din_valid, frame_sync,
        output dout, dout_valid, slot, locked, frame_err
    );

    modport master (
        output din, din_valid, frame_sync,
        input  dout, dout_valid, slot, locked, frame_err
    );
endinterface

// File: rtl/tdm_demux16.sv
// 16-slot serial TDM frame demultiplexer with HUNT/RUN sync lock and error-counted lock loss.
// Latency: 1 clk from the slot-15 bit to dout_valid; no backpressure, din_valid gaps simply stall the slot counter.
module tdm_demux16 #(
    parameter int ERR_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux16_if.slave bus
);
    localparam int CW = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);

    typedef enum logic {HUNT, RUN} state_e;

    state_e        state_q, state_d;
    logic [3:0]    slot_q, slot_d;
    logic [14:0]   shadow_q, shadow_d;
    logic [15:0]   dout_q, dout_d;
    logic          dout_vld_q, dout_vld_d;
    logic          frame_err_q, frame_err_d;
    logic [CW-1:0] err_q, err_d;
    logic          err_hit;

    // This error is the one that reaches ERR_LIMIT; counter never exceeds the limit.
    assign err_hit = (err_q >= CW'(ERR_LIMIT - 1));

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        dout_d      = dout_q;
        dout_vld_d  = 1'b0;
        frame_err_d = 1'b0;
        err_d       = err_q;
        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    slot_d = 4'd0;
                    if (bus.frame_sync) begin
                        shadow_d[0] = bus.din;
                        slot_d      = 4'd1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (slot_q == 4'd0 && bus.frame_sync) begin
                        shadow_d[0] = bus.din;
                        slot_d      = 4'd1;
                        err_d       = '0;
                    end else if (slot_q == 4'd0 || bus.frame_sync) begin
                        frame_err_d = 1'b1;
                        if (err_hit) begin
                            // Lock loss wins over restarting on an early sync bit.
                            state_d = HUNT;
                            slot_d  = 4'd0;
                            err_d   = '0;
                        end else begin
                            err_d = err_q + CW'(1);
                            if (bus.frame_sync) begin
                                shadow_d[0] = bus.din;
                                slot_d      = 4'd1;
                            end
                        end
                    end else if (slot_q == 4'd15) begin
                        dout_d     = {bus.din, shadow_q};
                        dout_vld_d = 1'b1;
                        slot_d     = 4'd0;
                        err_d      = '0;
                    end else begin
                        shadow_d[slot_q] = bus.din;
                        slot_d           = slot_q + 4'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= 4'd0;
            shadow_q    <= '0;
            dout_q      <= 16'h0000;
            dout_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            frame_err_q <= frame_err_d;
            err_q       <= err_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_vld_q;
    assign bus.slot       = slot_q;
    assign bus.locked     = (state_q == RUN);
    assign bus.frame_err  = frame_err_q;
endmodule
